// File: rtl/nlms_pkg.sv
`default_nettype none
// ============================================================================
// nlms_pkg : shared types for the NLMS input aligner (sample, pair, state)
// Revision : 1.0
// ============================================================================
package nlms_pkg;

  localparam int DEFAULT_ITEM_W = 32;

  typedef logic [DEFAULT_ITEM_W-1:0] sample_t;

  typedef struct packed {
    sample_t d;
    sample_t x;
  } pair_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN_X = 2'd1,
    DRAIN_D = 2'd2
  } align_state_t;

endpackage
`default_nettype wire

// File: rtl/nlms_input_aligner_if.sv
`default_nettype none
// ============================================================================
// nlms_input_aligner_if : AXI-Stream style beat bus (data, last, valid, ready)
// Revision : 1.0
// ============================================================================
interface nlms_input_aligner_if #(
  parameter int DW = 32
) ();

  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface
`default_nettype wire

// File: rtl/nlms_align_fifo.sv
`default_nettype none
// ============================================================================
// nlms_align_fifo : synchronous FIFO carrying a data word plus its tlast bit
// Revision : 1.0
// ============================================================================
module nlms_align_fifo #(
  parameter int W          = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_last_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_data_o,
  output logic         head_last_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        w_push;
  logic        w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign w_push = wr_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  assign {head_last_o, head_data_o} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last_i, wr_data_i};
  end

endmodule
`default_nettype wire

// File: rtl/nlms_input_aligner.sv
`default_nettype none
// ============================================================================
// nlms_input_aligner : pairs x/d streams into {d,x} beats, resyncs on tlast skew
// Optional macro NLMS_ALIGN_STATS_EN adds the 32-bit pair_count output.
// Revision : 1.0
// ============================================================================
module nlms_input_aligner
  import nlms_pkg::*;
#(
  parameter int ITEM_W     = DEFAULT_ITEM_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  nlms_input_aligner_if.slave  s_x,
  nlms_input_aligner_if.slave  s_d,
  nlms_input_aligner_if.master m,
  input  logic                 enable,
  input  logic                 clear_err,
  output logic                 mismatch_err,
  output logic [CNT_W-1:0]     mismatch_count
`ifdef NLMS_ALIGN_STATS_EN
  ,
  output logic [31:0]          pair_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              w_x_full, w_x_empty, w_x_last, w_x_pop;
  logic              w_d_full, w_d_empty, w_d_last, w_d_pop;
  logic [ITEM_W-1:0] w_x_data, w_d_data;
  logic              w_load, w_mis;

  align_state_t        state_q, state_d;
  logic                valid_q;
  logic                last_q;
  logic [2*ITEM_W-1:0] data_q;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Ready is held low while reset is asserted, not just while full.
  assign s_x.tready = !w_x_full && !ce_rst;
  assign s_d.tready = !w_d_full && !ce_rst;

  nlms_align_fifo #(
    .W          (ITEM_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_x (
    .clk         (ce_clk),
    .rst         (ce_rst),
    .wr_i        (s_x.tvalid && s_x.tready),
    .wr_data_i   (s_x.tdata),
    .wr_last_i   (s_x.tlast),
    .pop_i       (w_x_pop),
    .full_o      (w_x_full),
    .empty_o     (w_x_empty),
    .head_data_o (w_x_data),
    .head_last_o (w_x_last)
  );

  nlms_align_fifo #(
    .W          (ITEM_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_d (
    .clk         (ce_clk),
    .rst         (ce_rst),
    .wr_i        (s_d.tvalid && s_d.tready),
    .wr_data_i   (s_d.tdata),
    .wr_last_i   (s_d.tlast),
    .pop_i       (w_d_pop),
    .full_o      (w_d_full),
    .empty_o     (w_d_empty),
    .head_data_o (w_d_data),
    .head_last_o (w_d_last)
  );

  always_comb begin
    state_d = state_q;
    w_x_pop = 1'b0;
    w_d_pop = 1'b0;
    w_load  = 1'b0;
    w_mis   = 1'b0;
    case (state_q)
      RUN: begin
        if (enable && !w_x_empty && !w_d_empty && (!valid_q || m.tready)) begin
          w_x_pop = 1'b1;
          w_d_pop = 1'b1;
          w_load  = 1'b1;
          if (w_x_last && !w_d_last) begin
            w_mis   = 1'b1;
            state_d = DRAIN_D;
          end else if (w_d_last && !w_x_last) begin
            w_mis   = 1'b1;
            state_d = DRAIN_X;
          end
        end
      end
      // Drains ignore enable and the output stage; the tlast beat is dropped too.
      DRAIN_D: begin
        if (!w_d_empty) begin
          w_d_pop = 1'b1;
          if (w_d_last) state_d = RUN;
        end
      end
      DRAIN_X: begin
        if (!w_x_empty) begin
          w_x_pop = 1'b1;
          if (w_x_last) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (w_mis) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
    end else if (clear_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // A mismatched pair is the end of the emitted packet, hence OR of the lasts.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (w_load) begin
      valid_q <= 1'b1;
      last_q  <= w_x_last || w_d_last;
      data_q  <= {w_d_data, w_x_data};
    end else if (m.tready) begin
      valid_q <= 1'b0;
    end
  end

  assign m.tvalid       = valid_q;
  assign m.tlast        = last_q;
  assign m.tdata        = data_q;
  assign mismatch_err   = err_q;
  assign mismatch_count = cnt_q;

`ifdef NLMS_ALIGN_STATS_EN
  logic [31:0] pair_cnt_q;

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      pair_cnt_q <= '0;
    end else if (valid_q && m.tready) begin
      pair_cnt_q <= pair_cnt_q + 32'd1;
    end
  end

  assign pair_count = pair_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nlms_input_aligner.sv
`default_nettype none
// ============================================================================
// tb_nlms_input_aligner : directed + random bench with a packet-level pairing model
// Revision : 1.0
// ============================================================================
module tb_nlms_input_aligner;
  import nlms_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    pair_t p;
    logic  last;
  } obeat_t;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b0;
  logic        enable = 1'b0;
  logic        clear_err = 1'b0;
  logic        mismatch_err;
  logic [15:0] mismatch_count;
`ifdef NLMS_ALIGN_STATS_EN
  logic [31:0] pair_count;
  int          hs_cnt = 0;
`endif

  nlms_input_aligner_if #(.DW(32)) x_if ();
  nlms_input_aligner_if #(.DW(32)) d_if ();
  nlms_input_aligner_if #(.DW(64)) m_if ();

  nlms_input_aligner #(
    .ITEM_W     (32),
    .FIFO_DEPTH (8),
    .CNT_W      (16)
  ) dut (
    .ce_clk         (ce_clk),
    .ce_rst         (ce_rst),
    .s_x            (x_if),
    .s_d            (d_if),
    .m              (m_if),
    .enable         (enable),
    .clear_err      (clear_err),
    .mismatch_err   (mismatch_err),
    .mismatch_count (mismatch_count)
`ifdef NLMS_ALIGN_STATS_EN
    ,
    .pair_count     (pair_count)
`endif
  );

  always #5 ce_clk = ~ce_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus queues, accepted-beat queues and expected output.
  beat_t  txx[$], txd[$];
  beat_t  mx[$], md[$];
  obeat_t exp_q[$];
  bit     drain_x = 0, drain_d = 0;
  logic [15:0] model_cnt = '0;
  logic   model_err = 1'b0;
  bit     hold = 0, rnd_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Pairing rules applied to whatever the two streams have delivered so far.
  task automatic model_run();
    beat_t  bx, bd;
    obeat_t o;
    bit     go = 1;
    while (go) begin
      if (drain_d) begin
        if (md.size() == 0) go = 0;
        else begin bd = md.pop_front(); if (bd.last) drain_d = 0; end
      end else if (drain_x) begin
        if (mx.size() == 0) go = 0;
        else begin bx = mx.pop_front(); if (bx.last) drain_x = 0; end
      end else if (mx.size() > 0 && md.size() > 0) begin
        bx = mx.pop_front();
        bd = md.pop_front();
        o.p.d  = bd.data;
        o.p.x  = bx.data;
        o.last = bx.last | bd.last;
        exp_q.push_back(o);
        if (bx.last != bd.last) begin
          if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
          model_err = 1'b1;
          if (bx.last) drain_d = 1; else drain_x = 1;
        end
      end else begin
        go = 0;
      end
    end
  endtask

  task automatic send(input bit is_d, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      if (is_d) txd.push_back(b); else txx.push_back(b);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge ce_clk);
      if (txx.size() == 0 && txd.size() == 0 && exp_q.size() == 0 && !m_if.tvalid) break;
    end
    chk(tag, 64'(exp_q.size() + txx.size() + txd.size()), 64'd0);
  endtask

  initial begin : drv_x
    bit acc;
    x_if.tvalid = 1'b0;
    x_if.tdata  = '0;
    x_if.tlast  = 1'b0;
    forever begin
      @(negedge ce_clk);
      acc = x_if.tvalid && x_if.tready && !ce_rst;
      @(posedge ce_clk);
      #1;
      if (acc) begin mx.push_back(txx.pop_front()); model_run(); end
      if (hold) x_if.tvalid = 1'b0;
      else if (!x_if.tvalid || acc) begin
        if (txx.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
          x_if.tvalid = 1'b1;
          x_if.tdata  = txx[0].data;
          x_if.tlast  = txx[0].last;
        end else x_if.tvalid = 1'b0;
      end
    end
  end

  initial begin : drv_d
    bit acc;
    d_if.tvalid = 1'b0;
    d_if.tdata  = '0;
    d_if.tlast  = 1'b0;
    forever begin
      @(negedge ce_clk);
      acc = d_if.tvalid && d_if.tready && !ce_rst;
      @(posedge ce_clk);
      #1;
      if (acc) begin md.push_back(txd.pop_front()); model_run(); end
      if (hold) d_if.tvalid = 1'b0;
      else if (!d_if.tvalid || acc) begin
        if (txd.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
          d_if.tvalid = 1'b1;
          d_if.tdata  = txd[0].data;
          d_if.tlast  = txd[0].last;
        end else d_if.tvalid = 1'b0;
      end
    end
  end

  always @(negedge ce_clk) begin
    obeat_t e;
    if (!ce_rst && m_if.tvalid && m_if.tready) begin
`ifdef NLMS_ALIGN_STATS_EN
      hs_cnt++;
`endif
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL out_unexpected: observed beat %h expected no beat", m_if.tdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", m_if.tdata, e.p);
        chk("out_last", 64'(m_if.tlast), 64'(e.last));
      end
    end
  end

  initial begin : main
    int t0, lat;
    bit seen;
    m_if.tready = 1'b1;

    // Reset state
    #1 ce_rst = 1'b1;
    #10;
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_tdata", m_if.tdata, 64'd0);
    chk("rst_err", 64'(mismatch_err), 64'd0);
    chk("rst_cnt", 64'(mismatch_count), 64'd0);
    chk("rst_xready", 64'(x_if.tready), 64'd0);
    chk("rst_dready", 64'(d_if.tready), 64'd0);
    @(negedge ce_clk);
    ce_rst = 1'b0;
    enable = 1'b1;
    #1;
    chk("rel_xready", 64'(x_if.tready), 64'd1);
    chk("rel_dready", 64'(d_if.tready), 64'd1);

    // 1: aligned 64-beat packets, latency of the first pair
    @(negedge ce_clk);
    send(0, 64);
    send(1, 64);
    seen = 0; t0 = 0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge ce_clk);
      if (!seen && x_if.tvalid && x_if.tready) begin seen = 1; t0 = i; end
      if (seen && m_if.tvalid) begin lat = i - t0; break; end
    end
    chk("t1_latency", 64'(lat), 64'd2);
    wait_drain("t1_drain", 200);
    chk("t1_cnt", 64'(mismatch_count), 64'd0);

    // 2: x runs 8 ahead, d arrives 20 cycles later
    send(0, 8);
    for (int i = 0; i < 30; i++) begin
      @(negedge ce_clk);
      if (txx.size() == 0) break;
    end
    @(negedge ce_clk);
    chk("t2_xready_full", 64'(x_if.tready), 64'd0);
    chk("t2_no_out", 64'(m_if.tvalid), 64'd0);
    repeat (20) @(negedge ce_clk);
    send(1, 8);
    wait_drain("t2_drain", 100);

    // 3: x packet of 4 vs d packet of 6, then aligned 4-beat packets
    send(0, 4); send(1, 6);
    send(0, 4); send(1, 4);
    wait_drain("t3_drain", 100);
    chk("t3_err", 64'(mismatch_err), 64'd1);
    chk("t3_cnt", 64'(mismatch_count), 64'd1);

    // 4: output stalled while both streams push
    m_if.tready = 1'b0;
    send(0, 12); send(1, 12);
    repeat (4) @(negedge ce_clk);
    chk("t4_hold_a", m_if.tdata, exp_q[0].p);
    repeat (10) @(negedge ce_clk);
    chk("t4_hold_b", m_if.tdata, exp_q[0].p);
    chk("t4_valid", 64'(m_if.tvalid), 64'd1);
    chk("t4_xready", 64'(x_if.tready), 64'd0);
    chk("t4_dready", 64'(d_if.tready), 64'd0);
    m_if.tready = 1'b1;
    wait_drain("t4_drain", 100);

    // 6: clear_err coincides with a new mismatch
    enable = 1'b0;
    send(0, 2); send(1, 3);
    repeat (10) @(negedge ce_clk);
    chk("t6_held", 64'(m_if.tvalid), 64'd0);
    enable = 1'b1;
    @(negedge ce_clk);
    clear_err = 1'b1;
    @(negedge ce_clk);
    clear_err = 1'b0;
    chk("t6_err_kept", 64'(mismatch_err), 64'(model_err));
    chk("t6_cnt", 64'(mismatch_count), 64'(model_cnt));
    wait_drain("t6_drain", 50);
    clear_err = 1'b1;
    @(negedge ce_clk);
    clear_err = 1'b0;
    model_err = 1'b0;
    @(negedge ce_clk);
    chk("t6_err_clr", 64'(mismatch_err), 64'(model_err));
    chk("t6_cnt_kept", 64'(mismatch_count), 64'(model_cnt));

    // 7: random packet lengths, gaps, backpressure and enable
    rnd_mode = 1;
    for (int p = 0; p < 20; p++) begin
      int lx;
      lx = $urandom_range(1, 6);
      send(0, lx);
      send(1, ($urandom_range(0, 1) != 0) ? lx : int'($urandom_range(1, 6)));
    end
    for (int i = 0; i < 600; i++) begin
      @(negedge ce_clk);
      m_if.tready = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
    end
    rnd_mode = 0;
    m_if.tready = 1'b1;
    enable = 1'b1;
    repeat (300) @(negedge ce_clk);
    chk("t7_left", 64'(exp_q.size()), 64'd0);
    chk("t7_cnt", 64'(mismatch_count), 64'(model_cnt));
    chk("t7_err", 64'(mismatch_err), 64'(model_err));

    // 5: asynchronous reset mid-packet
    hold = 1;
    repeat (3) @(negedge ce_clk);
    txx.delete(); txd.delete();
    hold = 0;
    m_if.tready = 1'b0;
    send(0, 6); send(1, 6);
    repeat (6) @(negedge ce_clk);
    chk("t5_pre_valid", 64'(m_if.tvalid), 64'(exp_q.size() != 0));
    #2;
    ce_rst = 1'b1;
    hold = 1;
    #1;
    chk("t5_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("t5_tdata", m_if.tdata, 64'd0);
    chk("t5_cnt", 64'(mismatch_count), 64'd0);
    chk("t5_err", 64'(mismatch_err), 64'd0);
    chk("t5_xready", 64'(x_if.tready), 64'd0);
    @(posedge ce_clk);
    #3 ce_rst = 1'b0;
    @(negedge ce_clk);
    txx.delete(); txd.delete(); mx.delete(); md.delete(); exp_q.delete();
    drain_x = 0; drain_d = 0; model_cnt = '0; model_err = 1'b0;
    chk("t5_x_empty", 64'(x_if.tready), 64'd1);
    chk("t5_d_empty", 64'(d_if.tready), 64'd1);
    chk("t5_no_out", 64'(m_if.tvalid), 64'd0);
`ifdef NLMS_ALIGN_STATS_EN
    chk("t5_pairs", 64'(pair_count), 64'd0);
    hs_cnt = 0;
`endif
    hold = 0;
    m_if.tready = 1'b1;
    send(0, 4); send(1, 4);
    wait_drain("t5_drain", 50);
    chk("t5_cnt_after", 64'(mismatch_count), 64'(model_cnt));
`ifdef NLMS_ALIGN_STATS_EN
    chk("pair_count", 64'(pair_count), 64'(hs_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nlms_input_aligner.md
Name: nlms_input_aligner

Overview:
- Upstream stage of the NLMS adaptive-filter block; runs in the ce_clk domain, between the two CHDR-to-AXIS data ports and the NLMS core.
- Input port 0 carries the reference signal x; input port 1 carries the desired signal d.
- Buffers each stream independently and emits one beat per matched {d, x} sample pair.
- Detects packet-boundary (tlast) misalignment between the streams and resynchronises by discarding the lagging stream's remainder.

Parameters:
- ITEM_W, 32: width of one sc16 sample (16-bit I + 16-bit Q).
- FIFO_DEPTH, 8: per-input FIFO depth; power of two, at least 2.
- CNT_W, 16: width of the mismatch counter.

Ports:
- ce_clk  in  1  block clock; all logic synchronous to it.
- ce_rst  in  1  asynchronous, active-high reset.
- s_x_tdata  in  ITEM_W  reference sample.
- s_x_tlast / s_x_tvalid  in  1 each  end of packet / valid for x.
- s_x_tready  out  1  ready for x.
- s_d_tdata / s_d_tlast / s_d_tvalid / s_d_tready: same as x, for the desired stream.
- m_tdata  out  2*ITEM_W  pair, {d[ITEM_W-1:0], x[ITEM_W-1:0]} (d in the upper half).
- m_tlast / m_tvalid  out  1 each.
- m_tready  in  1.
- enable  in  1  when 0, pairing is held off.
- clear_err  in  1  single-cycle pulse; clears the sticky flag.
- mismatch_err  out  1  sticky misalignment flag.
- mismatch_count  out  CNT_W  number of misalignment events.

Behaviour:
- Reset: ce_rst is asynchronous, active-high.
  - Both FIFOs emptied; state RUN.
  - m_tvalid=0, m_tlast=0, m_tdata=0.
  - mismatch_err=0, mismatch_count=0.
  - s_x_tready and s_d_tready are 0 while ce_rst is high and 1 on the first cycle after release.
- Inputs:
  - s_*_tready = !fifo_full for that stream.
  - A write occurs on tvalid && tready.
  - The two streams are fully independent; one may run up to FIFO_DEPTH beats ahead of the other.
- Output register:
  - Single registered stage. It loads when a pop occurs and (!m_tvalid || m_tready).
  - m_tvalid clears on m_tready with no new load.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
- Latency: a beat written at cycle N is visible at the FIFO head at N+1. When both heads are present and enable=1, m_tvalid rises at N+2. Full throughput is 1 pair/cycle.
- Pairing condition: pairing happens only when enable=1. With enable=0 there are no pops; the FIFOs fill and backpressure the inputs, and the output register drains normally.
- State RUN: pop when both heads are valid and the output register can load.
  - Both head tlasts equal: emit the pair, with m_tlast = that tlast value.
  - x.tlast=1 and d.tlast=0:
    - Emit the pair with m_tlast=1.
    - mismatch_count increments, saturating at 2^CNT_W-1.
    - mismatch_err is set.
    - Go to DRAIN_D.
  - d.tlast=1 and x.tlast=0: symmetric, go to DRAIN_X.
- State DRAIN_D: pop d only, 1 beat/cycle, regardless of enable and the output register. Nothing is emitted. The popped beat with tlast=1 is discarded, then return to RUN. DRAIN_X is symmetric.
- Error flag: clear_err and a new mismatch in the same cycle leaves mismatch_err=1. clear_err does not reset mismatch_count.
- Reset mid-operation: any in-flight pair and all FIFO contents are lost. No partial output beat is presented after reset.
- Full/empty: a simultaneous write and pop on a full FIFO is not allowed, because tready=0 when full. A simultaneous write and pop on an empty FIFO keeps it empty-then-valid next cycle; there is no bypass path.

Optional Feature:
- Macro: NLMS_ALIGN_STATS_EN.
- Defined: adds output pair_count (32 bits). It increments on each m_tvalid && m_tready handshake, wraps modulo 2^32, and is reset to 0 by ce_rst.
- Undefined: the port is absent, along with its counter logic.

Decomposition:
- Shared package nlms_pkg:
  - localparam ITEM_W default.
  - typedef sample_t (logic [ITEM_W-1:0]).
  - typedef packed struct pair_t {sample_t d; sample_t x;}.
  - enum align_state_t {RUN, DRAIN_X, DRAIN_D}.
- Sub-module nlms_align_fifo:
  - Synchronous FIFO with tlast; parameter FIFO_DEPTH.
  - Ports: full/empty/head/pop.
  - Instantiated twice.

Test Plan:
1. Stream 64 x and 64 d beats, each packet ending with tlast on beat 63, no stalls. Expect 64 pairs {d_i, x_i}, m_tlast only on pair 63, first m_tvalid 2 cycles after the first handshakes, mismatch_count=0.
2. Send 8 beats of x then, 20 cycles later, 8 beats of d. Expect s_x_tready to drop after 8 beats, then 8 correctly paired outputs once d arrives.
3. x packet of 4 beats (tlast on beat 3), d packet of 6 beats (tlast on beat 5), then aligned 4-beat packets. Expect:
   - 4 pairs, the 4th with m_tlast=1.
   - d beats 4–5 discarded.
   - mismatch_err=1 and mismatch_count=1.
   - The next packet pairs correctly.
4. Hold m_tready=0 for 10 cycles with both streams active. Expect m_tdata stable, both FIFOs to fill to 8, both treadys=0; then the data resumes in order with none lost.
5. Assert ce_rst for 1 cycle mid-packet, asynchronously to the ce_clk edge. Expect immediate m_tvalid=0, counters=0, and the FIFOs empty. A fresh 4-beat aligned packet afterwards pairs correctly.
6. Pulse clear_err in the same cycle as a new mismatch event. Expect mismatch_err=1 and mismatch_count to increment. A later clear_err alone gives mismatch_err=0 with the count retained.
